// File: rtl/stdout_uart.sv
// Memory-mapped console transmitter: CPU stores are queued in a small FIFO
// and sent as 8N1 UART frames; a status register exposes empty/full/active/overflow.
module stdout_uart #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          BAUD_DIV   = 868,
    parameter logic [23:0] ADDR_DATA  = 24'hFFFFFE,
    parameter logic [23:0] ADDR_STAT  = 24'hFFFFFD
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic        i_clk_en,
    input  logic [23:0] i_addr,
    input  logic [31:0] i_din,
    input  logic        i_wr,
    output logic        o_sel,
    output logic [31:0] o_dout,
    output logic        o_txd,
    output logic        o_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              clr;
    logic              ovf_q;

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              txd_q;
    logic              txd_d;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign push_req = i_clk_en & i_wr & (i_addr == ADDR_DATA);
    // A pop in the same cycle frees a slot, so a store into a full FIFO still lands
    assign push     = push_req & (~full | pop);
    assign clr      = i_clk_en & i_wr & (i_addr == ADDR_STAT) & i_din[3];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_din[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            ovf_q <= 1'b0;
        end else if (push_req & full & ~pop) begin
            ovf_q <= 1'b1;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end
    end

    // txd_d is the line level for the next cycle, so o_txd comes straight off a flop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (i_clk_en) begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        baud_d  = BAUD_LOAD;
                        state_d = START;
                        txd_d   = 1'b0;
                    end
                end
                START: begin
                    if (baud_q == '0) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                        baud_d  = BAUD_LOAD;
                        txd_d   = shift_q[0];
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == '0) begin
                        baud_d  = BAUD_LOAD;
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            txd_d = shift_q[1];
                        end
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == '0) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = mem[rd_ptr];
                            baud_d  = BAUD_LOAD;
                            state_d = START;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign o_sel  = (i_addr == ADDR_DATA) | (i_addr == ADDR_STAT);
    assign o_dout = (i_addr == ADDR_STAT) ?
                    {28'd0, ovf_q, (state_q != IDLE), full, empty} : 32'd0;
    assign o_txd  = txd_q;
    assign o_busy = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_stdout_uart.sv
// Bench for stdout_uart: a frame-level model (byte queue plus position inside the
// current 10-bit frame) checked every cycle, plus directed literal expectations.
module tb_stdout_uart;

    localparam int          B      = 4;
    localparam int          DEPTH  = 8;
    localparam logic [23:0] A_DATA = 24'hFFFFFE;
    localparam logic [23:0] A_STAT = 24'hFFFFFD;

    logic        i_clk    = 1'b0;
    logic        i_rstb   = 1'b0;
    logic        i_clk_en = 1'b1;
    logic [23:0] i_addr   = A_STAT;
    logic [31:0] i_din    = 32'd0;
    logic        i_wr     = 1'b0;
    logic        o_sel;
    logic [31:0] o_dout;
    logic        o_txd;
    logic        o_busy;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    stdout_uart #(
        .FIFO_DEPTH(DEPTH),
        .BAUD_DIV  (B),
        .ADDR_DATA (A_DATA),
        .ADDR_STAT (A_STAT)
    ) dut (
        .i_clk   (i_clk),
        .i_rstb  (i_rstb),
        .i_clk_en(i_clk_en),
        .i_addr  (i_addr),
        .i_din   (i_din),
        .i_wr    (i_wr),
        .o_sel   (o_sel),
        .o_dout  (o_dout),
        .o_txd   (o_txd),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Model: queued bytes, and when a frame is on the line, the byte plus its enabled-cycle offset
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'd0;
    bit         m_ovf    = 1'b0;
    int         m_sz;
    bit         m_pop, m_push, m_clr;

    always @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else if (i_clk_en) begin
            m_sz   = q.size();
            m_push = i_wr && (i_addr == A_DATA);
            m_clr  = i_wr && (i_addr == A_STAT) && i_din[3];
            m_pop  = (m_sz > 0) && (!m_active || m_pos == 10*B-1);
            if (m_active && m_pos != 10*B-1) begin
                m_pos++;
            end else if (m_pop) begin
                m_byte   = q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_active = 1'b0;
            end
            if (m_push && (m_sz < DEPTH || m_pop)) q.push_back(i_din[7:0]);
            if (m_push && m_sz == DEPTH && !m_pop) m_ovf = 1'b1;
            else if (m_clr) m_ovf = 1'b0;
        end
    end

    function automatic logic model_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_pos / B;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    function automatic logic [31:0] model_status();
        return {28'd0, m_ovf, m_active, (q.size() == DEPTH), (q.size() == 0)};
    endfunction

    task automatic checkOutput();
        logic        e_txd, e_busy, e_sel;
        logic [31:0] e_dout;
        e_txd  = model_txd();
        e_busy = m_active || (q.size() > 0);
        e_sel  = (i_addr == A_DATA) || (i_addr == A_STAT);
        e_dout = (i_addr == A_STAT) ? model_status() : 32'd0;
        vectors++;
        if (o_txd !== e_txd) begin
            miscompares++;
            $display("[TB] FAIL txd t=%0t: got %b want %b", $time, o_txd, e_txd);
        end
        if (o_busy !== e_busy) begin
            miscompares++;
            $display("[TB] FAIL busy t=%0t: got %b want %b", $time, o_busy, e_busy);
        end
        if (o_sel !== e_sel) begin
            miscompares++;
            $display("[TB] FAIL sel t=%0t: got %b want %b", $time, o_sel, e_sel);
        end
        if (o_dout !== e_dout) begin
            miscompares++;
            $display("[TB] FAIL dout t=%0t: got %h want %h", $time, o_dout, e_dout);
        end
    endtask

    always @(negedge i_clk) begin
        if (check_en) checkOutput();
    end

    task automatic checkLiteral(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [23:0] addr,
                                 input logic [31:0] din, input logic cen);
        @(posedge i_clk);
        #2;
        i_wr     = wr;
        i_addr   = addr;
        i_din    = din;
        i_clk_en = cen;
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n;
        n = 0;
        while (o_busy && n < bound) begin
            applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
            n++;
        end
        if (o_busy) begin
            miscompares++;
            $display("[TB] FAIL %s: timeout after %0d cycles, busy still %b", name, bound, o_busy);
        end
    endtask

    logic [0:9]   fr_41 = 10'b0100000101;
    logic [0:9]   fr_h  = 10'b0000100101;
    logic [0:9]   fr_i  = 10'b0100101101;
    logic [0:9]   fr_55 = 10'b0101010101;
    logic [127:0] got_v, exp_v;
    logic         busy40, busy41;
    int           n, cnt;
    bit           started, stored;

    initial begin
        i_addr = A_STAT;
        repeat (3) @(posedge i_clk);
        #1;
        checkLiteral("reset_status", o_dout, 32'h1);
        checkLiteral("reset_sel", o_sel, 1);
        checkLiteral("reset_txd", o_txd, 1);
        checkLiteral("reset_busy", o_busy, 0);
        @(posedge i_clk);
        #2;
        i_rstb   = 1'b1;
        check_en = 1'b1;

        // Single frame of 'A'
        applyStimulus(1'b1, A_DATA, 32'h00000041, 1'b1);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        got_v = '0;
        exp_v = '0;
        for (int k = 0; k < 42; k++) begin
            @(negedge i_clk);
            got_v[k] = o_txd;
            if (k == 40) busy40 = o_busy;
            if (k == 41) busy41 = o_busy;
            exp_v[k] = (k == 0 || k == 41) ? 1'b1 : fr_41[(k-1)/4];
        end
        checkLiteral("frame_41_bits", got_v, exp_v);
        checkLiteral("frame_41_busy_stop", busy40, 1);
        checkLiteral("frame_41_busy_idle", busy41, 0);

        // Back-to-back 'H','i'
        applyStimulus(1'b1, A_DATA, 32'hABCDEF48, 1'b1);
        applyStimulus(1'b1, A_DATA, 32'h00000069, 1'b1);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        got_v = '0;
        exp_v = '0;
        for (int k = 0; k < 81; k++) begin
            @(negedge i_clk);
            got_v[k] = o_txd;
            exp_v[k] = (k < 40) ? fr_h[k/4] : (k < 80) ? fr_i[(k-40)/4] : 1'b1;
        end
        checkLiteral("frames_hi_bits", got_v, exp_v);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        #1;
        checkLiteral("hi_done_status", o_dout, 32'h1);

        // Ten stores into a depth-8 FIFO while the first frame runs
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, A_DATA, 32'h30 + k, 1'b1);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        #1;
        checkLiteral("ovf_status", o_dout, 32'hE);
        applyStimulus(1'b1, A_STAT, 32'h8, 1'b1);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        #1;
        checkLiteral("ovf_cleared", o_dout, 32'h6);

        // Store on the exact cycle the transmitter pops from a full FIFO
        n = 0;
        while (!(m_active && m_pos == 10*B-1 && q.size() == DEPTH) && n < 200) begin
            applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("[TB] FAIL pop_push_wait: timeout, pos %0d size %0d", m_pos, q.size());
        end
        i_wr   = 1'b1;
        i_addr = A_DATA;
        i_din  = 32'h77;
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        #1;
        checkLiteral("full_pop_push_status", o_dout, 32'h6);
        waitIdle("drain", 2000);
        #1;
        checkLiteral("drained_status", o_dout, 32'h1);

        // Reset during data bit 3 with five bytes still queued
        applyStimulus(1'b1, A_DATA, 32'h00, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, A_DATA, $urandom, 1'b1);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        n = 0;
        while (!(m_active && m_pos == 17) && n < 100) begin
            applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
            n++;
        end
        checkLiteral("pre_reset_txd", o_txd, 0);
        i_rstb = 1'b0;
        #1;
        checkLiteral("async_reset_txd", o_txd, 1);
        checkLiteral("async_reset_busy", o_busy, 0);
        checkLiteral("async_reset_status", o_dout, 32'h1);
        @(posedge i_clk);
        #2;
        i_rstb = 1'b1;
        repeat (60) applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        #1;
        checkLiteral("post_reset_busy", o_busy, 0);

        // 50% clock enable during a frame of 0x55; one store issued with enable low
        applyStimulus(1'b1, A_DATA, 32'h55, 1'b1);
        started = 1'b0;
        stored  = 1'b0;
        cnt     = 0;
        got_v   = '0;
        exp_v   = '0;
        for (int k = 0; k < 400; k++) begin
            @(posedge i_clk);
            #2;
            i_wr     = 1'b0;
            i_addr   = A_STAT;
            i_clk_en = ~i_clk_en;
            if (!i_clk_en && k >= 10 && !stored) begin
                i_wr   = 1'b1;
                i_addr = A_DATA;
                i_din  = 32'hAA;
                stored = 1'b1;
            end
            @(negedge i_clk);
            if (!started && !o_txd) started = 1'b1;
            if (started) begin
                if (!o_busy) break;
                if (cnt < 128) got_v[cnt] = o_txd;
                cnt++;
            end
        end
        for (int k = 0; k < 80; k++) exp_v[k] = fr_55[k/8];
        checkLiteral("cen_span", cnt, 80);
        checkLiteral("cen_bits", got_v, exp_v);
        applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        repeat (5) applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
        #1;
        checkLiteral("cen_ignored_store", o_dout, 32'h1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [23:0] a;
            case ($urandom_range(0, 3))
                0, 1:    a = A_DATA;
                2:       a = A_STAT;
                default: a = 24'($urandom);
            endcase
            applyStimulus($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(0, 7) != 0);
            i_rstb = ($urandom_range(0, 499) != 0);
        end
        i_rstb = 1'b1;
        waitIdle("final_drain", 2000);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
